// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART RX controller slice: capture FSM state
//   encoding, host register addresses and STATUS/CTRL bit positions.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Capture FSM: one push and one ack per character raised by the receiver.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } cap_state_e;

    // Host register byte addresses.
    localparam logic [11:0] ADDR_RX_DATA = 12'h004;
    localparam logic [11:0] ADDR_STATUS  = 12'h008;
    localparam logic [11:0] ADDR_CTRL    = 12'h00C;

    // STATUS bit positions.
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVR_BIT   = 2;
    localparam int STAT_PERR_BIT  = 3;
    localparam int STAT_UNF_BIT   = 4;
    localparam int STAT_RTS_BIT   = 8;
    localparam int STAT_LEVEL_LSB = 16;

    // CTRL bit positions.
    localparam int CTRL_FLUSH_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_host_if
//   Host register bus between the CPU side and uart_rx_ctrl.
//   master : drives rd_en/raddr/wr_en/waddr/wdata, receives rdata.
//   slave  : the controller; receives strobes/addresses, returns rdata
//            (registered, valid the cycle after rd_en).
// -----------------------------------------------------------------------------
interface uart_host_if;
    logic        rd_en;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        wr_en;
    logic [11:0] waddr;
    logic [31:0] wdata;

    modport master (
        output rd_en, raddr, wr_en, waddr, wdata,
        input  rdata
    );

    modport slave (
        input  rd_en, raddr, wr_en, waddr, wdata,
        output rdata
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock FIFO with first-word-fall-through head.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     push_i, wdata_i  write request and data (ignored while full)
//     pop_i            read request (ignored while empty)
//     flush_i          empties the FIFO at the next edge; overrides push/pop
//     rdata_o          head entry, valid whenever empty_o=0
//     full_o, empty_o  occupancy flags
//     level_o          number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Occupancy is judged on the pre-edge state: a pop never frees a slot
    // for a push in the same cycle, and a push never feeds a same-cycle pop.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers are AW bits wide, so increments wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    // NOTE: storage has no reset; pointers and level alone define validity,
    // and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   Drains characters from the UART receiver core into an RX FIFO, serves
//   host reads, keeps sticky RX status, drives rts_n flow control with
//   hysteresis and raises a level/error interrupt.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     rx_done_i    receiver character-ready (level, held until acked)
//     rx_data_i    received character
//     rx_perr_i    parity error flag for that character
//     rx_ack_o     one-cycle pulse releasing the receiver's rx_done
//     host         register bus (slave side): RX_DATA 0x004, STATUS 0x008,
//                  CTRL 0x00C; rdata registered, valid the cycle after rd_en
//     rts_n        flow control to the remote sender, 1 = stop
//     irq          level interrupt
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int RTS_HI  = 12,
    parameter int RTS_LO  = 4,
    parameter int IRQ_LVL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_done_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_perr_i,
    output logic        rx_ack_o,
    uart_host_if.slave  host,
    output logic        rts_n,
    output logic        irq
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] RTS_HI_LVL = LW'(RTS_HI);
    localparam logic [LW-1:0] RTS_LO_LVL = LW'(RTS_LO);
    localparam logic [LW-1:0] IRQ_LVL_L  = LW'(IRQ_LVL);

    // ---------------------------------------------------------------- state
    cap_state_e  state_q;
    logic        rx_ack_q;
    logic        ovr_q,    ovr_d;
    logic        perr_q,   perr_d;
    logic        unf_q,    unf_d;
    logic        irq_en_q, irq_en_d;
    logic        rts_q,    rts_d;
    logic        irq_q,    irq_d;
    logic [31:0] rdata_q,  rdata_d;

    // ---------------------------------------------------------------- decode
    logic        wr_status;
    logic        wr_ctrl;
    logic        rd_rx;
    logic        flush;
    logic        capture;
    logic        push_ok;
    logic        ovr_set;
    logic        perr_set;
    logic        unf_set;

    logic        fifo_full;
    logic        fifo_empty;
    logic [8:0]  fifo_head;
    logic [LW-1:0] fifo_level;

    logic [31:0] status_word;
    logic [31:0] ctrl_word;

    // Only bits [4:0] of a write carry meaning.
    logic        unused_wdata;
    assign unused_wdata = ^host.wdata[31:5];

    assign wr_status = host.wr_en & (host.waddr == ADDR_STATUS);
    assign wr_ctrl   = host.wr_en & (host.waddr == ADDR_CTRL);
    assign rd_rx     = host.rd_en & (host.raddr == ADDR_RX_DATA);
    assign flush     = wr_ctrl & host.wdata[CTRL_FLUSH_BIT];

    // A character is taken only on entry from IDLE; ACK/WAIT shield the
    // FIFO from a receiver flag that stays high past the ack.
    assign capture  = (state_q == ST_IDLE) & rx_done_i;
    assign push_ok  = capture & ~fifo_full & ~flush;
    // A flushed character is discarded on purpose, so it is not an overrun.
    assign ovr_set  = capture & fifo_full & ~flush;
    assign perr_set = push_ok & rx_perr_i;
    assign unf_set  = rd_rx & fifo_empty;

    // ---------------------------------------------------------------- FIFO
    uart_sync_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_ok),
        .wdata_i ({rx_perr_i, rx_data_i}),
        .pop_i   (rd_rx & ~fifo_empty),
        .flush_i (flush),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // ---------------------------------------------------------------- capture FSM
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rx_ack_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_done_i) begin
                        state_q  <= ST_ACK;
                        rx_ack_q <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_q  <= ST_WAIT;
                    rx_ack_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (!rx_done_i) state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    rx_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ack_o = rx_ack_q;

    // ---------------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        status_word                              = '0;
        status_word[STAT_EMPTY_BIT]              = fifo_empty;
        status_word[STAT_FULL_BIT]               = fifo_full;
        status_word[STAT_OVR_BIT]                = ovr_q;
        status_word[STAT_PERR_BIT]               = perr_q;
        status_word[STAT_UNF_BIT]                = unf_q;
        status_word[STAT_RTS_BIT]                = rts_q;
        status_word[STAT_LEVEL_LSB +: LW]        = fifo_level;

        // Flush reads back as 0: it is a strobe, not a stored bit.
        ctrl_word                                = '0;
        ctrl_word[CTRL_IRQ_EN_BIT]               = irq_en_q;

        rdata_d = rdata_q;
        if (host.rd_en) begin
            case (host.raddr)
                ADDR_RX_DATA: rdata_d = fifo_empty ? 32'd0 : {23'd0, fifo_head};
                ADDR_STATUS:  rdata_d = status_word;
                ADDR_CTRL:    rdata_d = ctrl_word;
                default:      rdata_d = 32'd0;
            endcase
        end

        // Write-1-to-clear, with a same-cycle set taking priority.
        ovr_d  = (ovr_q  & ~(wr_status & host.wdata[STAT_OVR_BIT]))  | ovr_set;
        perr_d = (perr_q & ~(wr_status & host.wdata[STAT_PERR_BIT])) | perr_set;
        unf_d  = (unf_q  & ~(wr_status & host.wdata[STAT_UNF_BIT]))  | unf_set;

        irq_en_d = wr_ctrl ? host.wdata[CTRL_IRQ_EN_BIT] : irq_en_q;

        // Hysteresis band: between the thresholds the previous value holds.
        rts_d = rts_q;
        if (fifo_level >= RTS_HI_LVL) begin
            rts_d = 1'b1;
        end else if (fifo_level <= RTS_LO_LVL) begin
            rts_d = 1'b0;
        end

        irq_d = irq_en_q & ((fifo_level >= IRQ_LVL_L) | ovr_q | perr_q);
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
            unf_q    <= 1'b0;
            irq_en_q <= 1'b1;
            rts_q    <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
            unf_q    <= unf_d;
            irq_en_q <= irq_en_d;
            rts_q    <= rts_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign host.rdata = rdata_q;
    assign rts_n      = rts_q;
    assign irq        = irq_q;

endmodule
